shared_sample_arbiter: RTL and testbench

Round-robin arbiter that shares one registered sample bit (`y`, synchronous-reset capture flop) among N requesters. Each requester raises `req` and presents its data bit on `din`. The arbiter grants one requester at a time for up to HOLD consecutive captures, registers that requester's bit into `y` each granted cycle, and tags the output with the source index. It sits between the stimulus sources and the single-bit capture register, which becomes a time-shared resource.

---
 rtl/shared_sample_arbiter.sv | 162 ++++++++++++++++
 tb/tb_shared_sample_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/shared_sample_arbiter.sv
// shared_sample_arbiter
// Round-robin arbiter that time-shares one registered sample bit among N
// requesters. The winner holds the grant for up to HOLD captures, or less if
// it drops its request, and every capture is tagged with its source index.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; the next owner is picked from ptr upward, mod N
// OWN   | requester w is granted; its din bit is captured while req[w]=1
module shared_sample_arbiter #(
    parameter int N     = 4,
    parameter int SRC_W = 2,
    parameter int HOLD  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     din,
    output logic [N-1:0]     gnt,
    output logic             y,
    output logic             y_valid,
    output logic [SRC_W-1:0] y_src
);

    localparam int               CNT_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);
    localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(N - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [SRC_W-1:0]   r_ptr;
    logic [SRC_W-1:0]   r_w;
    logic [CNT_W-1:0]   r_cnt;
    logic [N-1:0]       r_gnt;
    logic               r_y;
    logic               r_y_valid;
    logic [SRC_W-1:0]   r_y_src;

    state_t             w_state_nxt;
    logic [SRC_W-1:0]   w_ptr_nxt;
    logic [SRC_W-1:0]   w_w_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [N-1:0]       w_gnt_nxt;
    logic               w_y_nxt;
    logic               w_y_valid_nxt;
    logic [SRC_W-1:0]   w_y_src_nxt;

    logic               w_found;
    logic [SRC_W-1:0]   w_pick;
    logic [SRC_W:0]     w_dist;
    logic [SRC_W:0]     w_best;
    logic [SRC_W-1:0]   w_ptr_after;
    logic               w_own_req;

    // Pointer value used on any release: the slot just after the current owner.
    always_comb begin
        w_ptr_after = (r_w == SRC_LAST) ? '0 : r_w + 1'b1;
        w_own_req   = req[r_w];
    end

    // Round-robin pick: the requester with the smallest distance from ptr wins.
    // Distance is (k - ptr) mod N, computed one bit wider to hold k + N.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_best  = (SRC_W + 1)'(N);
        w_dist  = '0;
        for (int k = 0; k < N; k++) begin
            if (SRC_W'(k) >= r_ptr) begin
                w_dist = (SRC_W + 1)'(k) - {1'b0, r_ptr};
            end else begin
                w_dist = (SRC_W + 1)'(k + N) - {1'b0, r_ptr};
            end
            if (req[k] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_pick  = SRC_W'(k);
                w_found = 1'b1;
            end
        end
    end

    // Next-state and next-output decode; every register holds unless changed.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_w_nxt       = r_w;
        w_cnt_nxt     = r_cnt;
        w_gnt_nxt     = r_gnt;
        w_y_nxt       = r_y;
        w_y_valid_nxt = 1'b0;
        w_y_src_nxt   = r_y_src;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_w_nxt     = w_pick;
                    w_gnt_nxt   = N'(1) << w_pick;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_OWN;
                end
            end

            ST_OWN: begin
                if (w_own_req) begin
                    w_y_nxt       = din[r_w];
                    w_y_valid_nxt = 1'b1;
                    w_y_src_nxt   = r_w;
                    if (r_cnt == CNT_LAST) begin
                        w_gnt_nxt   = '0;
                        w_ptr_nxt   = w_ptr_after;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else begin
                    // Owner let go early: release without capturing.
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = w_ptr_after;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset wins over capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_w       <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_y       <= 1'b0;
            r_y_valid <= 1'b0;
            r_y_src   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_w       <= w_w_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gnt     <= w_gnt_nxt;
            r_y       <= w_y_nxt;
            r_y_valid <= w_y_valid_nxt;
            r_y_src   <= w_y_src_nxt;
        end
    end

    assign gnt     = r_gnt;
    assign y       = r_y;
    assign y_valid = r_y_valid;
    assign y_src   = r_y_src;

endmodule

// File: tb/tb_shared_sample_arbiter.sv
// Bench for shared_sample_arbiter (N=4, HOLD=3). Each driven cycle pushes the
// expected registered outputs; a checker pops and compares them after the edge.
module tb_shared_sample_arbiter;

    localparam int N     = 4;
    localparam int SRC_W = 2;
    localparam int HOLD  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req;
    logic [N-1:0]     din;
    logic [N-1:0]     gnt;
    logic             y;
    logic             y_valid;
    logic [SRC_W-1:0] y_src;

    shared_sample_arbiter #(.N(N), .SRC_W(SRC_W), .HOLD(HOLD)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .y       (y),
        .y_valid (y_valid),
        .y_src   (y_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       gnt;
    } unused_t;

    typedef struct {
        logic [3:0] gnt;
        logic       y;
        logic       yv;
        logic [1:0] src;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] gnt;
        logic       y;
        logic       yv;
        logic [1:0] src;
    } vec_t;

    exp_t sb_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Checker: one expected record is consumed 1 time unit after every edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            chk("gnt",     32'(gnt),     32'(cur.gnt));
            chk("y",       32'(y),       32'(cur.y));
            chk("y_valid", 32'(y_valid), 32'(cur.yv));
            chk("y_src",   32'(y_src),   32'(cur.src));
        end
    end

    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] dn,
                        input logic [3:0] eg, input logic ey, input logic eyv,
                        input logic [1:0] es);
        exp_t e;
        reset = r;
        req   = rq;
        din   = dn;
        e.gnt = eg;
        e.y   = ey;
        e.yv  = eyv;
        e.src = es;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    vec_t       tbl[12];
    logic [3:0] dpat;
    logic       ey;
    logic [1:0] es;

    initial begin
        // rst, req, din -> gnt, y, y_valid, y_src
        tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 4'b0100, 4'b1011, 4'b0100, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2};
        tbl[4]  = '{1'b0, 4'b0100, 4'b1011, 4'b0100, 1'b0, 1'b1, 2'd2};
        tbl[5]  = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2};
        tbl[6]  = '{1'b0, 4'b0100, 4'b1011, 4'b0100, 1'b1, 1'b0, 2'd2};
        tbl[7]  = '{1'b0, 4'b0100, 4'b1011, 4'b0100, 1'b0, 1'b1, 2'd2};
        tbl[8]  = '{1'b0, 4'b0100, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2};
        tbl[9]  = '{1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2};
        tbl[10] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, 2'd2};
        tbl[11] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0};

        reset = 1'b1;
        req   = '0;
        din   = '0;

        // Reset values, single requester with regrant, idle with no request.
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].din,
                 tbl[i].gnt, tbl[i].y, tbl[i].yv, tbl[i].src);
        end

        // Round-robin from ptr=0 with all lines requesting: 0,1,2,3.
        dpat = 4'b0101;
        ey   = 1'b0;
        es   = 2'd0;
        for (int g = 0; g < 4; g++) begin
            step(1'b0, 4'b1111, dpat, 4'(1) << g, ey, 1'b0, es);
            for (int c = 0; c < HOLD; c++) begin
                ey = dpat[g];
                es = 2'(g);
                step(1'b0, 4'b1111, dpat, (c < HOLD - 1) ? (4'(1) << g) : 4'b0000,
                     ey, 1'b1, es);
            end
        end

        // Pointer wrapped to 0 after owner 3: req=1001 goes to 0.
        step(1'b0, 4'b1001, 4'b1110, 4'b0001, 1'b0, 1'b0, 2'd3);
        step(1'b0, 4'b1001, 4'b1110, 4'b0001, 1'b0, 1'b1, 2'd0);
        step(1'b0, 4'b1001, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0);
        step(1'b0, 4'b1001, 4'b1110, 4'b0000, 1'b0, 1'b1, 2'd0);

        // Early release by 1 after one capture; next search starts at 2.
        step(1'b0, 4'b0010, 4'b1101, 4'b0010, 1'b0, 1'b0, 2'd0);
        step(1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1);
        step(1'b0, 4'b1001, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd1);
        step(1'b0, 4'b1011, 4'b0000, 4'b1000, 1'b1, 1'b0, 2'd1);

        // Reset on the second capture of a grant to 3, then regrant from ptr=0.
        step(1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3);
        step(1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0, 2'd0);
        step(1'b0, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0, 2'd0);
        step(1'b0, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3);
        step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd3);

        #5;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
